// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared trap cause codes, sequencer states and request priority helper
package trap_ctrl_pkg;

  // Cause codes; encoding matches the csrs cause_in decoder
  typedef enum logic [1:0] {
    NOT_EXCEPTION       = 2'b00,
    I_ADDR_MISALIGNMENT = 2'b01,
    ILLEGAL_IR          = 2'b10
  } cause_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TRAP  = 2'b01,
    S_RET   = 2'b10,
    S_REDIR = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE     = 2'b00,
    REQ_ILLEGAL  = 2'b01,
    REQ_MRET     = 2'b10,
    REQ_MISALIGN = 2'b11
  } req_e;

  // Oldest instruction wins: ID-stage events beat the younger IF-stage fetch fault
  function automatic req_e prio_sel(input logic illegal, input logic mret, input logic misaligned);
    if (illegal)         return REQ_ILLEGAL;
    else if (mret)       return REQ_MRET;
    else if (misaligned) return REQ_MISALIGN;
    else                 return REQ_NONE;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/return sequencer driving csrs pulses, pipeline flush and PC redirect
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_misaligned,
  input  logic [31:0] i_if_pc,
  input  logic [31:0] i_if_target,
  input  logic        i_id_illegal,
  input  logic        i_id_mret,
  input  logic [31:0] i_id_pc,
  input  logic [31:0] i_id_ir,
  input  logic [31:0] i_mtvec_in,
  input  logic [31:0] i_mepc_in,
  output logic [1:0]  o_cause_out,
  output logic [31:0] o_epc_out,
  output logic [31:0] o_tval_out,
  output logic        o_is_mret,
  output logic        o_flush_n,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_busy
);

  state_e      r_state;
  cause_e      r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_tval;
  logic        r_is_mret;
  logic        r_flush_n;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;
  logic        r_busy;
  req_e        w_req;

  assign w_req = prio_sel(i_id_illegal, i_id_mret, i_if_misaligned);

  // Sequencer: IDLE samples requests, TRAP/RET pulse the csrs for one cycle, REDIR loads the PC.
  // epc/tval/redirect_pc are only rewritten when a new trap or redirect is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cause       <= NOT_EXCEPTION;
      r_epc         <= 32'h0;
      r_tval        <= 32'h0;
      r_is_mret     <= 1'b0;
      r_flush_n     <= 1'b1;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'h0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cause    <= NOT_EXCEPTION;
          r_is_mret  <= 1'b0;
          r_flush_n  <= 1'b1;
          r_redirect <= 1'b0;
          r_busy     <= 1'b0;
          case (w_req)
            REQ_ILLEGAL: begin
              r_state   <= S_TRAP;
              r_cause   <= ILLEGAL_IR;
              r_epc     <= i_id_pc;
              r_tval    <= i_id_ir;
              r_flush_n <= 1'b0;
              r_busy    <= 1'b1;
            end
            REQ_MRET: begin
              r_state   <= S_RET;
              r_is_mret <= 1'b1;
              r_flush_n <= 1'b0;
              r_busy    <= 1'b1;
            end
            REQ_MISALIGN: begin
              r_state   <= S_TRAP;
              r_cause   <= I_ADDR_MISALIGNMENT;
              r_epc     <= i_if_pc;
              r_tval    <= i_if_target;
              r_flush_n <= 1'b0;
              r_busy    <= 1'b1;
            end
            default: r_state <= S_IDLE;
          endcase
        end
        S_TRAP: begin
          r_state       <= S_REDIR;
          r_cause       <= NOT_EXCEPTION;
          r_redirect    <= 1'b1;
          r_redirect_pc <= i_mtvec_in;
        end
        S_RET: begin
          // mepc is captured here, before the csrs return update can disturb the read path
          r_state       <= S_REDIR;
          r_is_mret     <= 1'b0;
          r_redirect    <= 1'b1;
          r_redirect_pc <= i_mepc_in;
        end
        default: begin
          r_state    <= S_IDLE;
          r_flush_n  <= 1'b1;
          r_redirect <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_cause_out   = r_cause;
  assign o_epc_out     = r_epc;
  assign o_tval_out    = r_tval;
  assign o_is_mret     = r_is_mret;
  assign o_flush_n     = r_flush_n;
  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_misaligned, id_illegal, id_mret;
  logic [31:0] if_pc, if_target, id_pc, id_ir, mtvec_in, mepc_in;
  logic [1:0]  cause_out;
  logic [31:0] epc_out, tval_out, redirect_pc;
  logic        is_mret, flush_n, redirect, busy;

  int n_cmp = 0;
  int n_err = 0;

  trap_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_misaligned(if_misaligned), .i_if_pc(if_pc), .i_if_target(if_target),
    .i_id_illegal(id_illegal), .i_id_mret(id_mret), .i_id_pc(id_pc), .i_id_ir(id_ir),
    .i_mtvec_in(mtvec_in), .i_mepc_in(mepc_in),
    .o_cause_out(cause_out), .o_epc_out(epc_out), .o_tval_out(tval_out),
    .o_is_mret(is_mret), .o_flush_n(flush_n), .o_redirect(redirect),
    .o_redirect_pc(redirect_pc), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Model: a request taken in idle opens a two-cycle window (pulse cycle, redirect cycle)
  int          m_left;
  int          m_pos;
  logic        m_is_ret;
  logic [1:0]  m_code;
  logic [31:0] m_epc, m_tval, m_rpc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_pos = 0; m_is_ret = 0; m_code = 0;
      m_epc = 0; m_tval = 0; m_rpc = 0;
    end else if (m_left == 0) begin
      if (id_illegal) begin
        m_left = 2; m_is_ret = 0; m_code = 2'd2; m_epc = id_pc; m_tval = id_ir;
      end else if (id_mret) begin
        m_left = 2; m_is_ret = 1; m_code = 2'd0;
      end else if (if_misaligned) begin
        m_left = 2; m_is_ret = 0; m_code = 2'd1; m_epc = if_pc; m_tval = if_target;
      end
      m_pos = (m_left == 2) ? 1 : 0;
    end else begin
      if (m_pos == 1) m_rpc = m_is_ret ? mepc_in : mtvec_in;
      m_left = m_left - 1;
      m_pos = (m_left == 0) ? 0 : 2;
    end
  end

  function automatic logic [101:0] expected();
    logic [1:0] c;
    logic       mr, fl, rd, bz;
    c  = (m_pos == 1 && !m_is_ret) ? m_code : 2'd0;
    mr = (m_pos == 1 && m_is_ret);
    rd = (m_pos == 2);
    bz = (m_pos != 0);
    fl = !bz;
    return {c, m_epc, m_tval, mr, fl, rd, m_rpc, bz};
  endfunction

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic [101:0] act, exp_v;
      act   = {cause_out, epc_out, tval_out, is_mret, flush_n, redirect, redirect_pc, busy};
      exp_v = expected();
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL model t=%0t got %h want %h", $time, act, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  task automatic idle_inputs();
    if_misaligned = 0; id_illegal = 0; id_mret = 0;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 0; idle_inputs();
    if_pc = 0; if_target = 0; id_pc = 0; id_ir = 0;
    mtvec_in = 32'h0001_0100; mepc_in = 32'h0;
    cyc(2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flush_n", {31'd0, flush_n}, 32'd1);
    chk("rst_cause", {30'd0, cause_out}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    rst_n = 1;
    cyc(1);

    // Illegal instruction trap
    id_illegal = 1; id_pc = 32'h0001_0010; id_ir = 32'hFFFF_FFFF;
    cyc(1); idle_inputs();
    chk("ill_cause", {30'd0, cause_out}, 32'd2);
    chk("ill_epc", epc_out, 32'h0001_0010);
    chk("ill_tval", tval_out, 32'hFFFF_FFFF);
    chk("ill_flush_n", {31'd0, flush_n}, 32'd0);
    cyc(1);
    chk("ill_redirect", {31'd0, redirect}, 32'd1);
    chk("ill_rpc", redirect_pc, 32'h0001_0100);
    chk("ill_cause_clr", {30'd0, cause_out}, 32'd0);
    cyc(1);
    chk("ill_busy_done", {31'd0, busy}, 32'd0);
    chk("ill_epc_hold", epc_out, 32'h0001_0010);

    // Misaligned fetch trap
    mtvec_in = 32'h0001_0200;
    if_misaligned = 1; if_pc = 32'h0001_0020; if_target = 32'h0001_0022;
    cyc(1); idle_inputs();
    chk("mis_cause", {30'd0, cause_out}, 32'd1);
    chk("mis_tval", tval_out, 32'h0001_0022);
    chk("mis_epc", epc_out, 32'h0001_0020);
    cyc(1);
    chk("mis_rpc", redirect_pc, 32'h0001_0200);
    cyc(1);

    // MRET beats a same-cycle misaligned fetch
    mepc_in = 32'h0001_0044;
    id_mret = 1; if_misaligned = 1; if_target = 32'h0001_0066;
    cyc(1); idle_inputs();
    chk("ret_is_mret", {31'd0, is_mret}, 32'd1);
    chk("ret_cause", {30'd0, cause_out}, 32'd0);
    cyc(1);
    chk("ret_rpc", redirect_pc, 32'h0001_0044);
    chk("ret_pulse_end", {31'd0, is_mret}, 32'd0);
    chk("ret_tval_hold", tval_out, 32'h0001_0022);
    cyc(1);

    // Illegal beats a same-cycle MRET
    id_illegal = 1; id_mret = 1; id_pc = 32'h0001_0030; id_ir = 32'h0000_0000;
    cyc(1); idle_inputs();
    chk("both_is_mret", {31'd0, is_mret}, 32'd0);
    chk("both_cause", {30'd0, cause_out}, 32'd2);
    cyc(2);

    // Illegal held high: not retaken until idle resamples it
    id_illegal = 1; id_pc = 32'h0001_0050; id_ir = 32'h1234_5678;
    cyc(1);
    chk("hold_cause1", {30'd0, cause_out}, 32'd2);
    cyc(1);
    chk("hold_redir", {31'd0, redirect}, 32'd1);
    cyc(1);
    chk("hold_idle", {31'd0, busy}, 32'd0);
    cyc(1);
    chk("hold_cause2", {30'd0, cause_out}, 32'd2);
    idle_inputs();
    cyc(3);

    // Request arriving while busy is dropped
    if_misaligned = 1; if_pc = 32'h0001_0070; if_target = 32'h0001_0073;
    cyc(1); idle_inputs(); id_mret = 1; mepc_in = 32'h0001_0999;
    cyc(1); id_mret = 0;
    chk("drop_rpc", redirect_pc, 32'h0001_0200);
    cyc(1);
    cyc(1);
    chk("drop_no_ret", {31'd0, is_mret}, 32'd0);

    // Asynchronous reset in the middle of a trap
    id_illegal = 1; id_pc = 32'h0001_0080; id_ir = 32'hDEAD_BEEF;
    cyc(1); idle_inputs();
    #2 rst_n = 0;
    #1;
    chk("arst_cause", {30'd0, cause_out}, 32'd0);
    chk("arst_epc", epc_out, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_flush_n", {31'd0, flush_n}, 32'd1);
    cyc(1); rst_n = 1;
    cyc(2);
    chk("arst_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
